// File: rtl/mem_arbiter.sv
// Two-port (fetch / memory-stage) arbiter onto a byte-wide RAM with one-cycle read latency.
// Define MEM_ARB_FAIR_EN for alternating grants on contention; otherwise MEM has fixed priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mm_req,
  input  logic        mm_we,
  input  logic [31:0] mm_addr,
  input  logic [31:0] mm_wdata,
  input  logic [1:0]  mm_len,
  output logic        mm_done,
  output logic [31:0] mm_rdata,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  output logic        stl_if,
  output logic        stl_mm
);

  typedef enum logic [2:0] {IDLE, IF_RD, MM_RD, MM_WR, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] base, wdata, rbuf, asm_word;
  logic [2:0]  cnt, n_reg;
  logic [1:0]  cap_idx;
  logic        grant_mm, busy;

`ifdef MEM_ARB_FAIR_EN
  logic last_if;
  assign grant_mm = mm_req & (~if_req | last_if);
`else
  assign grant_mm = mm_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_mm)    state_nx = mm_we ? MM_WR : MM_RD;
        else if (if_req) state_nx = IF_RD;
      end
      IF_RD, MM_RD: if (cnt == n_reg)        state_nx = DONE;
      MM_WR:        if (cnt == n_reg - 3'd1) state_nx = DONE;
      DONE:         state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  // RAM-side signals are decoded from state/counter so reset silences them on the next cycle
  assign busy     = (state == IF_RD) || (state == MM_RD) || (state == MM_WR);
  assign ram_a    = busy ? base + {29'd0, cnt} : '0;
  assign ram_wr   = (state == MM_WR);
  assign ram_dout = (state == MM_WR) ? wdata[{cnt[1:0], 3'b000} +: 8] : '0;

  // Byte from cycle cnt-1 arrives now; merge it so the final byte can be published on the DONE edge
  assign cap_idx = 2'(cnt - 3'd1);
  always_comb begin
    asm_word = rbuf;
    asm_word[{cap_idx, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      n_reg    <= '0;
      base     <= '0;
      wdata    <= '0;
      rbuf     <= '0;
      if_done  <= 1'b0;
      mm_done  <= 1'b0;
      if_data  <= '0;
      mm_rdata <= '0;
`ifdef MEM_ARB_FAIR_EN
      last_if  <= 1'b1;
`endif
    end else begin
      if_done <= 1'b0;
      mm_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= '0;
          rbuf <= '0;
          if (state_nx != IDLE) begin
            base  <= grant_mm ? mm_addr : if_addr;
            wdata <= mm_wdata;
            if (!grant_mm)          n_reg <= 3'd4;
            else if (mm_len == 2'd0) n_reg <= 3'd1;
            else if (mm_len == 2'd1) n_reg <= 3'd2;
            else                     n_reg <= 3'd4;
`ifdef MEM_ARB_FAIR_EN
            last_if <= ~grant_mm;
`endif
          end
        end
        IF_RD, MM_RD: begin
          cnt <= cnt + 3'd1;
          if (cnt != 3'd0) rbuf <= asm_word;
          if (state_nx == DONE) begin
            if (state == IF_RD) begin
              if_data <= asm_word;
              if_done <= 1'b1;
            end else begin
              mm_rdata <= asm_word;
              mm_done  <= 1'b1;
            end
          end
        end
        MM_WR: begin
          cnt <= cnt + 3'd1;
          if (state_nx == DONE) mm_done <= 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign stl_if = if_req & ~if_done;
  assign stl_mm = mm_req & ~mm_done;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have exactly one clock, clk, and a synchronous, active-high reset, rst: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 The IF port SHALL be: if_req in 1, fetch request; if_addr in 32, fetch byte address; if_done out 1, completion pulse; if_data out 32, fetched word.
REQ-003 The MEM port SHALL be: mm_req in 1, access request; mm_we in 1, 1=store; mm_addr in 32, byte address; mm_wdata in 32, store data; mm_len in 2, 0=1B, 1=2B, 2=4B, 3=4B; mm_done out 1, completion pulse; mm_rdata out 32, load data.
REQ-004 The RAM port SHALL be: ram_a out 32, byte address; ram_dout out 8, write byte; ram_wr out 1, write strobe; ram_din in 8, read byte valid one cycle after its address.
REQ-005 The stall outputs SHALL be: stl_if out 1, fetch stage stall; stl_mm out 1, memory stage stall.

Function
REQ-006 The FSM SHALL have the states IDLE, IF_RD, MM_RD, MM_WR and DONE, and SHALL leave IDLE only on a request sampled in IDLE.
REQ-007 In IDLE with both requests high, the arbiter SHALL grant MEM (fixed priority, macro absent); with one request high, it SHALL grant that requester.
REQ-008 On grant, the arbiter SHALL latch the address, length, data and we into internal registers; later changes on the requester inputs SHALL be ignored until DONE.
REQ-009 Service cycle i SHALL be the i-th cycle in the busy state, with i starting at 0; N SHALL be 4 for IF and the decoded mm_len for MEM.
REQ-010 For reads, ram_a SHALL equal base+i for i=0..N-1; byte i SHALL be captured from ram_din in cycle i+1; the state SHALL go to DONE after cycle N.
REQ-011 For writes, ram_a SHALL equal base+i, ram_dout SHALL equal wdata[8i+7:8i] and ram_wr SHALL be 1 for i=0..N-1; the state SHALL go to DONE after cycle N-1.
REQ-012 Data SHALL be assembled little-endian; 1B/2B loads SHALL be zero-extended into mm_rdata, and sign extension is not done in this block.
REQ-013 In DONE the arbiter SHALL assert exactly one of if_done or mm_done for 1 cycle, SHALL sample no requests, and SHALL return to IDLE.
REQ-014 Fetch latency from grant edge to if_done SHALL be 6 cycles; a 1B load SHALL take 3 cycles and a 1B store 2 cycles.
REQ-015 if_data SHALL update only on if_done and mm_rdata only on a load's mm_done; both SHALL hold otherwise.
REQ-016 Outside MM_WR, ram_wr SHALL be 0; outside busy states, ram_a SHALL be 0.
REQ-017 stl_if SHALL equal if_req & ~if_done and stl_mm SHALL equal mm_req & ~mm_done, both combinational.
REQ-018 A requester dropping its req mid-service SHALL NOT abort the service; the done pulse SHALL still be issued.
REQ-019 No address alignment SHALL be required; address increment SHALL wrap modulo 2^32.

Reset
REQ-020 While rst=1 at a clock edge, the arbiter SHALL set state=IDLE, counter=0, if_done=0, mm_done=0, ram_wr=0, ram_a=0, ram_dout=0, if_data=0 and mm_rdata=0.
REQ-021 A reset mid-service SHALL abort the service: ram_wr SHALL be 0 from the next cycle and no done pulse SHALL be issued.

Configuration
REQ-022 With MEM_ARB_FAIR_EN defined, the arbiter SHALL use a 1-bit last-grant register (reset=IF), and simultaneous requests in IDLE SHALL go to the requester not served last.
REQ-023 With MEM_ARB_FAIR_EN undefined, the arbiter SHALL use fixed MEM priority and SHALL NOT contain a last-grant register.

Verification
REQ-024 The bench SHALL cover: if_req, if_addr=0x100, RAM bytes 0x11,0x22,0x33,0x44 -> if_data=0x44332211 with if_done 6 cycles after grant, ram_a 0x100..0x103.
REQ-025 The bench SHALL cover: mm_req, we=1, len=2, addr=0x200, wdata=0xA1B2C3D4 -> ram_wr for 4 cycles with bytes D4,C3,B2,A1 and mm_done in the 5th cycle.
REQ-026 The bench SHALL cover: if_req and mm_req asserted in the same cycle (macro absent) -> MEM served first, IF served afterwards, stl_if=1 throughout.
REQ-027 The bench SHALL cover: with MEM_ARB_FAIR_EN defined and both requests held continuously -> grants alternate starting with MEM (last grant after reset is IF).
REQ-028 The bench SHALL cover: rst pulsed during the 3rd byte of a store -> ram_wr=0 next cycle, no mm_done, FSM in IDLE.
REQ-029 The bench SHALL cover: load, len=0, addr=0xFFFFFFFF, byte 0x80 -> mm_rdata=0x00000080, mm_done 3 cycles after grant.
